arf_rat: RTL and testbench
==========================

// Module: arf_rat
// PURPOSE
// Retire-side consumer of the ROB plus dispatch-side rename lookup. Holds the architectural
// register file (ARF) and the register alias table (RAT: per-ARF-reg valid + ROB tag).
// Commits ROB retire writes into the ARF and releases RAT mappings whose tag matches the
// retiring ROB id. Renames destinations at dispatch and answers two source lookups for
// register read (ARF value or ROB tag). Flush drops all mappings on mispredict recovery.
// PARAMETERS
// N_ARF_REGS      32  architectural registers; reg 0 hardwired to zero
// REG_DATA_WIDTH  32  register data width
// ROB_N_ENTRIES   16  ROB depth; ROB_ID_W = $clog2(ROB_N_ENTRIES)
// PORTS
// clk               in   1         clock, all state updates on rising edge
// rst_aH            in   1         asynchronous, active-high reset
// dispatch_fire     in   1         dispatch handshake completes this cycle (valid & ready)
// dispatch_dst_valid in  1         dispatched instr writes a destination
// dispatch_dst_arf_id in 5         destination ARF index
// dispatch_rob_id   in   ROB_ID_W  ROB id allocated to the dispatched instr
// retire            in   1         ROB retires an entry with a destination this cycle
// retire_rob_id     in   ROB_ID_W  retiring ROB id
// retire_arf_id     in   5         retiring destination ARF index
// retire_reg_data   in   REG_DATA_WIDTH  retiring value
// flush             in   1         mispredict recovery: clear all RAT valid bits
// src1_arf_id       in   5         source 1 ARF index
// src1_renamed      out  1         1: value pending in ROB; read via src1_rob_id
// src1_rob_id       out  ROB_ID_W  RAT tag for source 1 (valid only if src1_renamed)
// src1_reg_data     out  REG_DATA_WIDTH  ARF value for source 1 (valid if !src1_renamed)
// src2_*            --   --        identical to src1_* for source 2
// BEHAVIOUR
// - Reset (async, rst_aH=1): all ARF regs = 0, all RAT valid = 0, all RAT tags = 0.
//   Outputs are combinational: during reset srcN_renamed=0, srcN_reg_data=0.
// - Retire write: on retire & retire_arf_id!=0, ARF[retire_arf_id] <= retire_reg_data next edge.
//   Writes to reg 0 are dropped; ARF[0] always reads 0.
// - RAT release: on retire, if RAT[retire_arf_id].valid & tag==retire_rob_id, clear valid.
//   Tag mismatch (younger rename exists) leaves the mapping intact.
// - Rename: on dispatch_fire & dispatch_dst_valid & dst_arf_id!=0,
//   RAT[dst] <= {valid=1, tag=dispatch_rob_id}.
// - Same cycle, same reg: rename beats release (RAT ends valid with the new tag);
//   the ARF write still occurs.
// - Flush: all RAT valid <= 0 next edge. Flush beats a same-cycle rename (rename dropped).
//   A same-cycle retire still writes the ARF.
// - Lookup (combinational, 0 latency): srcN_renamed = RAT[id].valid & id!=0;
//   srcN_rob_id = RAT[id].tag; srcN_reg_data = ARF[id].
// - Retire bypass: if retire & retire_arf_id==srcN_arf_id!=0 and RAT tag==retire_rob_id & valid,
//   then srcN_renamed=0 and srcN_reg_data=retire_reg_data. Lookups never see a
//   same-cycle rename (old mapping shown). Same-cycle rename of a source is the
//   dispatch stage's concern.
// - No handshake back-pressure: block is always ready for retire and dispatch.
// - Reset mid-operation: all state cleared immediately regardless of concurrent inputs.
// TESTING
// 1 reset -> lookup of x1..x31: renamed=0, data=0; retire to x0 with 0xDEAD -> x0 still reads 0
// 2 dispatch x5 rob 3 -> next cycle src1=x5: renamed=1, rob_id=3; retire rob 3 data 0x1234 ->
//   same cycle renamed=0, data=0x1234 (bypass); next cycle ARF x5=0x1234, renamed=0
// 3 dispatch x7 rob 2, later x7 rob 9; retire rob 2 -> ARF x7 updated, RAT x7 still rob 9
// 4 retire x4 rob 6 and dispatch x4 rob 11 same cycle -> ARF x4 written, RAT x4 = {1,11}
// 5 rename x1,x2,x3 then flush with concurrent dispatch x8 rob 4 -> all renamed=0, x8 not renamed
// 6 assert rst_aH mid-stream after several retires -> all ARF 0 and RAT invalid without clock edge

Source files
------------

// File: rtl/arf_rat.sv
`default_nettype none
// ============================================================================
// Module   : arf_rat
// Purpose  : Architectural register file plus register alias table.
//            Retire side: commits ROB results into the ARF and releases the
//            RAT mapping when the retiring ROB id is still the live rename.
//            Dispatch side: renames destinations and answers two combinational
//            source lookups (ARF value, or ROB tag when the value is pending).
//            Flush drops every mapping for mispredict recovery.
// Ports    : clk, rst_aH                 clock, async active-high reset
//            dispatch_fire/_dst_valid/_dst_arf_id/_rob_id   rename request
//            retire/_rob_id/_arf_id/_reg_data               commit request
//            flush                       clear all RAT valid bits
//            srcN_arf_id                 lookup index (N = 1, 2)
//            srcN_renamed/_rob_id/_reg_data  lookup result
// Revision : 1.0  initial release
// ============================================================================
module arf_rat #(
  parameter int N_ARF_REGS     = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ROB_N_ENTRIES  = 16,
  parameter int ROB_ID_W       = $clog2(ROB_N_ENTRIES),
  parameter int ARF_ID_W       = $clog2(N_ARF_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_aH,
  input  logic                      dispatch_fire,
  input  logic                      dispatch_dst_valid,
  input  logic [ARF_ID_W-1:0]       dispatch_dst_arf_id,
  input  logic [ROB_ID_W-1:0]       dispatch_rob_id,
  input  logic                      retire,
  input  logic [ROB_ID_W-1:0]       retire_rob_id,
  input  logic [ARF_ID_W-1:0]       retire_arf_id,
  input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
  input  logic                      flush,
  input  logic [ARF_ID_W-1:0]       src1_arf_id,
  output logic                      src1_renamed,
  output logic [ROB_ID_W-1:0]       src1_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src1_reg_data,
  input  logic [ARF_ID_W-1:0]       src2_arf_id,
  output logic                      src2_renamed,
  output logic [ROB_ID_W-1:0]       src2_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src2_reg_data
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [REG_DATA_WIDTH-1:0] arf_q       [N_ARF_REGS];
  logic [REG_DATA_WIDTH-1:0] arf_d       [N_ARF_REGS];
  logic                      rat_valid_q [N_ARF_REGS];
  logic                      rat_valid_d [N_ARF_REGS];
  logic [ROB_ID_W-1:0]       rat_tag_q   [N_ARF_REGS];
  logic [ROB_ID_W-1:0]       rat_tag_d   [N_ARF_REGS];

  logic w_retire_wr;
  logic w_rename;
  logic w_release;

  assign w_retire_wr = retire && (retire_arf_id != '0);
  assign w_rename    = dispatch_fire && dispatch_dst_valid &&
                       (dispatch_dst_arf_id != '0) && !flush;
  // Only release when the retiring instruction is still the youngest writer;
  // otherwise a younger rename owns the register and must stay visible.
  assign w_release   = retire && rat_valid_q[retire_arf_id] &&
                       (rat_tag_q[retire_arf_id] == retire_rob_id);

  // --------------------------------------------------------------------------
  // Next state. Order of the updates encodes priority:
  // release < rename < flush.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_ARF_REGS; i++) begin
      arf_d[i]       = arf_q[i];
      rat_valid_d[i] = rat_valid_q[i];
      rat_tag_d[i]   = rat_tag_q[i];
    end

    // ARF write happens even under flush: retirement is architectural.
    if (w_retire_wr) begin
      arf_d[retire_arf_id] = retire_reg_data;
    end

    if (w_release) begin
      rat_valid_d[retire_arf_id] = 1'b0;
    end

    if (w_rename) begin
      rat_valid_d[dispatch_dst_arf_id] = 1'b1;
      rat_tag_d[dispatch_dst_arf_id]   = dispatch_rob_id;
    end

    if (flush) begin
      for (int i = 0; i < N_ARF_REGS; i++) begin
        rat_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int i = 0; i < N_ARF_REGS; i++) begin
        arf_q[i]       <= '0;
        rat_valid_q[i] <= 1'b0;
        rat_tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_ARF_REGS; i++) begin
        arf_q[i]       <= arf_d[i];
        rat_valid_q[i] <= rat_valid_d[i];
        rat_tag_q[i]   <= rat_tag_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Source lookups. Both ports are identical; they only see registered RAT
  // state (never a same-cycle rename) plus the retire bypass.
  // --------------------------------------------------------------------------
  logic [ARF_ID_W-1:0]       w_src_id      [2];
  logic                      w_src_renamed [2];
  logic [ROB_ID_W-1:0]       w_src_tag     [2];
  logic [REG_DATA_WIDTH-1:0] w_src_data    [2];

  assign w_src_id[0] = src1_arf_id;
  assign w_src_id[1] = src2_arf_id;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    logic w_nonzero;
    logic w_bypass;

    assign w_nonzero = (w_src_id[gi] != '0);
    // The value being retired this cycle is exactly what the pending tag
    // would have produced, so forward it and report the source as ready.
    assign w_bypass  = w_release && w_nonzero &&
                       (retire_arf_id == w_src_id[gi]);

    assign w_src_renamed[gi] = rat_valid_q[w_src_id[gi]] && w_nonzero && !w_bypass;
    assign w_src_tag[gi]     = rat_tag_q[w_src_id[gi]];
    assign w_src_data[gi]    = w_bypass  ? retire_reg_data :
                               w_nonzero ? arf_q[w_src_id[gi]] : '0;
  end

  assign src1_renamed  = w_src_renamed[0];
  assign src1_rob_id   = w_src_tag[0];
  assign src1_reg_data = w_src_data[0];
  assign src2_renamed  = w_src_renamed[1];
  assign src2_rob_id   = w_src_tag[1];
  assign src2_reg_data = w_src_data[1];

endmodule
`default_nettype wire

// File: tb/tb_arf_rat.sv
`default_nettype none
// ============================================================================
// Module   : tb_arf_rat
// Purpose  : Directed self-checking bench for arf_rat.
// Revision : 1.0  initial release
// ============================================================================
module tb_arf_rat;

  logic        clk;
  logic        rst_aH;
  logic        dispatch_fire;
  logic        dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [3:0]  dispatch_rob_id;
  logic        retire;
  logic [3:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic [31:0] retire_reg_data;
  logic        flush;
  logic [4:0]  src1_arf_id;
  logic        src1_renamed;
  logic [3:0]  src1_rob_id;
  logic [31:0] src1_reg_data;
  logic [4:0]  src2_arf_id;
  logic        src2_renamed;
  logic [3:0]  src2_rob_id;
  logic [31:0] src2_reg_data;

  int n_vec;
  int n_err;

  arf_rat dut (
    .clk                 (clk),
    .rst_aH              (rst_aH),
    .dispatch_fire       (dispatch_fire),
    .dispatch_dst_valid  (dispatch_dst_valid),
    .dispatch_dst_arf_id (dispatch_dst_arf_id),
    .dispatch_rob_id     (dispatch_rob_id),
    .retire              (retire),
    .retire_rob_id       (retire_rob_id),
    .retire_arf_id       (retire_arf_id),
    .retire_reg_data     (retire_reg_data),
    .flush               (flush),
    .src1_arf_id         (src1_arf_id),
    .src1_renamed        (src1_renamed),
    .src1_rob_id         (src1_rob_id),
    .src1_reg_data       (src1_reg_data),
    .src2_arf_id         (src2_arf_id),
    .src2_renamed        (src2_renamed),
    .src2_rob_id         (src2_rob_id),
    .src2_reg_data       (src2_reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dispatch_fire       = 1'b0;
    dispatch_dst_valid  = 1'b0;
    dispatch_dst_arf_id = '0;
    dispatch_rob_id     = '0;
    retire              = 1'b0;
    retire_rob_id       = '0;
    retire_arf_id       = '0;
    retire_reg_data     = '0;
    flush               = 1'b0;
  endtask

  // Let the current inputs be captured on the next rising edge, then clear them.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic dispatch(input logic [4:0] dst, input logic [3:0] rob);
    dispatch_fire       = 1'b1;
    dispatch_dst_valid  = 1'b1;
    dispatch_dst_arf_id = dst;
    dispatch_rob_id     = rob;
  endtask

  task automatic do_retire(input logic [4:0] dst, input logic [3:0] rob, input logic [31:0] data);
    retire          = 1'b1;
    retire_arf_id   = dst;
    retire_rob_id   = rob;
    retire_reg_data = data;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    src1_arf_id = '0;
    src2_arf_id = '0;
    rst_aH = 1'b1;
    #12;
    rst_aH = 1'b0;
    #2;

    // ---- 1: reset state and x0 immunity --------------------------------
    for (int r = 1; r < 32; r++) begin
      src1_arf_id = 5'(r);
      src2_arf_id = 5'(32 - r);
      #1;
      chk($sformatf("rst_ren_x%0d", r), 32'(src1_renamed), 32'd0);
      chk($sformatf("rst_dat_x%0d", r), src1_reg_data, 32'd0);
      chk($sformatf("rst_dat2_x%0d", 32 - r), src2_reg_data, 32'd0);
    end
    do_retire(5'd0, 4'd0, 32'hDEAD);
    dispatch(5'd0, 4'd7);
    step();
    src1_arf_id = 5'd0;
    #1;
    chk("x0_data", src1_reg_data, 32'd0);
    chk("x0_ren",  32'(src1_renamed), 32'd0);

    // ---- 2: rename, bypass on retire, commit ---------------------------
    dispatch(5'd5, 4'd3);
    src1_arf_id = 5'd5;
    #1;
    chk("x5_no_sameclk_ren", 32'(src1_renamed), 32'd0);
    step();
    chk("x5_ren",   32'(src1_renamed), 32'd1);
    chk("x5_robid", 32'(src1_rob_id),  32'd3);
    do_retire(5'd5, 4'd3, 32'h1234);
    #1;
    chk("x5_byp_ren",  32'(src1_renamed), 32'd0);
    chk("x5_byp_data", src1_reg_data,     32'h1234);
    step();
    chk("x5_arf",      src1_reg_data,     32'h1234);
    chk("x5_rel_ren",  32'(src1_renamed), 32'd0);

    // ---- 3: younger rename survives older retire -----------------------
    dispatch(5'd7, 4'd2);
    step();
    dispatch(5'd7, 4'd9);
    step();
    src2_arf_id = 5'd7;
    do_retire(5'd7, 4'd2, 32'h7777);
    #1;
    chk("x7_nobyp_ren", 32'(src2_renamed), 32'd1);
    chk("x7_nobyp_tag", 32'(src2_rob_id),  32'd9);
    step();
    chk("x7_ren",  32'(src2_renamed), 32'd1);
    chk("x7_tag",  32'(src2_rob_id),  32'd9);
    chk("x7_arf",  src2_reg_data,     32'h7777);

    // ---- 4: rename beats same-cycle release ----------------------------
    dispatch(5'd4, 4'd6);
    step();
    do_retire(5'd4, 4'd6, 32'h4444);
    dispatch(5'd4, 4'd11);
    step();
    src1_arf_id = 5'd4;
    #1;
    chk("x4_ren",  32'(src1_renamed), 32'd1);
    chk("x4_tag",  32'(src1_rob_id),  32'd11);
    chk("x4_arf",  src1_reg_data,     32'h4444);

    // ---- 5: flush beats rename, retire still writes --------------------
    dispatch(5'd1, 4'd1);
    step();
    dispatch(5'd2, 4'd2);
    step();
    dispatch(5'd3, 4'd3);
    step();
    src1_arf_id = 5'd1;
    src2_arf_id = 5'd3;
    #1;
    chk("x1_pre_ren", 32'(src1_renamed), 32'd1);
    chk("x3_pre_tag", 32'(src2_rob_id),  32'd3);
    flush = 1'b1;
    dispatch(5'd8, 4'd4);
    do_retire(5'd9, 4'd0, 32'h9999);
    step();
    for (int r = 1; r <= 8; r++) begin
      src1_arf_id = 5'(r);
      #1;
      chk($sformatf("flush_ren_x%0d", r), 32'(src1_renamed), 32'd0);
    end
    src2_arf_id = 5'd9;
    #1;
    chk("flush_x9_arf", src2_reg_data, 32'h9999);
    src2_arf_id = 5'd4;
    #1;
    chk("flush_x4_arf", src2_reg_data, 32'h4444);

    // ---- 6: async reset mid-stream --------------------------------------
    do_retire(5'd10, 4'd1, 32'hAAAA);
    step();
    do_retire(5'd11, 4'd2, 32'hBBBB);
    dispatch(5'd12, 4'd5);
    step();
    src1_arf_id = 5'd10;
    src2_arf_id = 5'd12;
    #1;
    chk("pre_rst_x10", src1_reg_data, 32'hAAAA);
    chk("pre_rst_x12", 32'(src2_renamed), 32'd1);
    // Reset asserted between edges with traffic still on the inputs.
    @(negedge clk);
    do_retire(5'd10, 4'd0, 32'h5555);
    dispatch(5'd10, 4'd8);
    #1;
    rst_aH = 1'b1;
    #1;
    chk("rst_x10_data", src1_reg_data,     32'd0);
    chk("rst_x12_ren",  32'(src2_renamed), 32'd0);
    chk("rst_x12_tag",  32'(src2_rob_id),  32'd0);
    src1_arf_id = 5'd11;
    src2_arf_id = 5'd5;
    #1;
    chk("rst_x11_data", src1_reg_data, 32'd0);
    chk("rst_x5_data",  src2_reg_data, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_aH = 1'b0;
    #1;
    chk("post_rst_x11", src1_reg_data, 32'd0);
    chk("post_rst_x5_ren", 32'(src2_renamed), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
